sine_addr_gen: RTL and testbench
================================

# sine_addr_gen

Phase-accumulator address generator that drives the sine lookup ROM directly upstream of it. It produces the shared phase address for both ROM read ports, plus the registered phase offset for the second port. New frequency/offset settings are accepted through a valid/ready handshake and take effect only at a phase wrap, so the output waveform never glitches mid-cycle. Outputs are registered; the ROM read is combinational, so sample data is valid in the same cycle as the address.

## Interface
- ADDRESS_WIDTH, 8, ROM address width (integer phase bits)
- FRAC_WIDTH, 8, fractional phase bits; accumulator width P = ADDRESS_WIDTH+FRAC_WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  advance phase each cycle while high
- phase_clr  in  1  synchronous phase reset to 0
- cfg_valid  in  1  new incr/offset offered
- cfg_ready  out  1  generator can accept a config
- cfg_incr  in  P  phase increment per cycle (unsigned)
- cfg_offset  in  ADDRESS_WIDTH  port-2 phase offset
- addr1  out  ADDRESS_WIDTH  phase[P-1:FRAC_WIDTH]
- addr2  out  ADDRESS_WIDTH  identical to addr1 (ROM adds offset)
- offset  out  ADDRESS_WIDTH  active offset
- wrap  out  1  one-cycle pulse: phase overflowed on the edge that produced current addr

## Operation
- Registers: phase[P], incr[P], offset, pend_incr, pend_offset, pending flag, state.
- States: IDLE (en low), RUN (en high, no pending), PEND (en high, config held).
- Reset: phase=0, incr=1<<FRAC_WIDTH (one address/cycle), offset=0, addr1=addr2=0, wrap=0, cfg_ready=1, state IDLE.
- Handshake: transfer when cfg_valid && cfg_ready. cfg_ready = !pending. cfg_* must be held stable while cfg_valid high and not accepted.
- IDLE: phase holds; accepted config loads incr/offset directly on the accepting edge. en=1 -> RUN.
- RUN: phase <= phase + incr (mod 2^P); carry-out sets wrap next cycle. Accepted config -> pend_*, pending=1, -> PEND.
- PEND: advance as RUN; on the edge whose add carries out, incr<=pend_incr, offset<=pend_offset, pending=0 -> RUN. New incr applies to the following add; new offset is visible together with the wrapped addr.
- Acceptance cycle that also carries out: config is not applied on that wrap; it waits for the next wrap.
- en falling in PEND: -> IDLE and pending config is applied on that same edge.
- phase_clr: highest priority after reset; phase<=0, wrap<=0, any pending config applied, state -> IDLE if en=0 else RUN. phase_clr with simultaneous cfg accept: accepted config applied immediately.
- cfg_incr=0 legal: phase freezes; pending config then waits until en drops or phase_clr.
- Reset mid-operation: all registers to reset values immediately; pending config discarded.

## Timing
- addr1/addr2/offset/wrap registered; update one edge after the controlling input.
- en rises at edge k: first advanced addr visible after edge k+1.
- cfg_ready falls the cycle after acceptance in RUN; rises the cycle after the applying wrap.
- Throughput: one sample per clock; no bubbles on config apply.

## Structure
- Package sinegen_pkg: state enum (IDLE, RUN, PEND), default ADDRESS_WIDTH/FRAC_WIDTH constants, reset increment constant.
- One sub-module natural: phase_acc (P-bit register + adder, carry-out, synchronous clear, hold). FSM and config staging in the top.

## Test plan
- Reset, en=1, default incr=0x0100: addr1 = 0,1,2..255,0; wrap pulses once per 256 cycles, coincident with addr=0.
- In IDLE accept incr=0x0080, offset=64: next cycle offset=64, cfg_ready=1; en=1 -> addr advances every 2 cycles.
- RUN at addr=100, incr=0x0100, accept incr=0x0200/offset=10: cfg_ready=0; addr continues 101..255; at wrap addr=0, offset=10, then 2,4,6; cfg_ready=1.
- Config accepted on the same cycle phase carries 0xFF00->0x0000: not applied at that wrap; applied at following wrap 256 cycles later.
- PEND with en dropped at addr=50: phase holds at 50, pending config applied immediately, cfg_ready=1 next cycle.
- rst_n asserted asynchronously mid-PEND: outputs 0 immediately without clock, incr back to 0x0100, pending discarded.

Source files
------------

// File: rtl/sine_addr_gen_pkg.sv
// Shared types and defaults for the sine ROM phase-address generator.
package sinegen_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    // Reset increment steps exactly one ROM address per cycle.
    function automatic int unsigned rst_incr(input int fw);
        return 32'd1 << fw;
    endfunction
endpackage

// File: rtl/sine_addr_gen_phase_acc.sv
// Phase accumulator: P-bit phase register, adder with carry-out, clear and hold.
module phase_acc #(
    parameter int AW = 8,
    parameter int FW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    input  logic [AW+FW-1:0]   incr,
    output logic [AW-1:0]      addr,
    output logic               carry
);
    localparam int P = AW + FW;

    logic [P-1:0] phase;
    logic [P-1:0] sum;

    assign {carry, sum} = {1'b0, phase} + {1'b0, incr};
    assign addr         = phase[P-1:FW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (clr)
            phase <= '0;
        else if (adv)
            phase <= sum;
    end
endmodule

// File: rtl/sine_addr_gen.sv
// Phase-address generator for the dual-port sine ROM; config changes land only on a phase wrap.
module sine_addr_gen
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int FRAC_WIDTH    = FRAC_W_DEF,
    localparam int P            = ADDRESS_WIDTH + FRAC_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     phase_clr,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [P-1:0]             cfg_incr,
    input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     wrap
);
    localparam logic [P-1:0] RST_INCR = P'(rst_incr(FRAC_WIDTH));

    state_t                   state, state_d;
    logic [P-1:0]             incr, pend_incr;
    logic [ADDRESS_WIDTH-1:0] offset_q, pend_offset;
    logic                     pending, wrap_q;
    logic                     acc, adv, carry;
    logic                     load_cfg, stage_cfg, apply_pend;
    logic [ADDRESS_WIDTH-1:0] addr;

    assign cfg_ready = !pending;
    assign acc       = cfg_valid && cfg_ready;

    phase_acc #(.AW(ADDRESS_WIDTH), .FW(FRAC_WIDTH)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_clr),
        .adv   (adv),
        .incr  (incr),
        .addr  (addr),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        adv        = 1'b0;
        load_cfg   = 1'b0;
        stage_cfg  = 1'b0;
        apply_pend = 1'b0;
        if (phase_clr) begin
            apply_pend = pending;
            load_cfg   = acc;
            state_d    = en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    load_cfg = acc;
                    if (en) state_d = RUN;
                end
                RUN: begin
                    if (!en) begin
                        load_cfg = acc;
                        state_d  = IDLE;
                    end else begin
                        adv = 1'b1;
                        if (acc) begin
                            stage_cfg = 1'b1;
                            state_d   = PEND;
                        end
                    end
                end
                PEND: begin
                    if (!en) begin
                        apply_pend = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        adv = 1'b1;
                        // Swap on the carrying edge so the new offset appears with the wrapped address.
                        if (carry) begin
                            apply_pend = 1'b1;
                            state_d    = RUN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr        <= RST_INCR;
            offset_q    <= '0;
            pend_incr   <= '0;
            pend_offset <= '0;
            pending     <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            wrap_q <= adv && carry;
            if (stage_cfg) begin
                pend_incr   <= cfg_incr;
                pend_offset <= cfg_offset;
                pending     <= 1'b1;
            end else if (apply_pend) begin
                pending <= 1'b0;
            end
            if (load_cfg) begin
                incr     <= cfg_incr;
                offset_q <= cfg_offset;
            end else if (apply_pend) begin
                incr     <= pend_incr;
                offset_q <= pend_offset;
            end
        end
    end

    assign addr1  = addr;
    assign addr2  = addr;
    assign offset = offset_q;
    assign wrap   = wrap_q;
endmodule

// File: tb/tb_sine_addr_gen.sv
// Scoreboard bench for sine_addr_gen: per-edge reference model queues expectations, negedge monitor compares.
module tb_sine_addr_gen;
    localparam int AW = 8;
    localparam int FW = 8;
    localparam int P  = AW + FW;
    localparam int unsigned MOD = 1 << P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en = 1'b0, phase_clr = 1'b0, cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [P-1:0]  cfg_incr = '0;
    logic [AW-1:0] cfg_offset = '0;
    logic [AW-1:0] addr1, addr2, offset;
    logic          wrap;

    sine_addr_gen #(.ADDRESS_WIDTH(AW), .FRAC_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_incr(cfg_incr),
        .cfg_offset(cfg_offset), .addr1(addr1), .addr2(addr2),
        .offset(offset), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] off;
        logic          wrap;
        logic          rdy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the generator's behaviour described as plain arithmetic on integers.
    int unsigned m_phase, m_incr, m_off, m_pincr, m_poff;
    bit          m_pend, m_run, m_wrap, acc_seen;

    function automatic exp_t snap();
        exp_t e;
        e.addr = AW'(m_phase >> FW);
        e.off  = AW'(m_off);
        e.wrap = m_wrap;
        e.rdy  = !m_pend;
        return e;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_incr = 1 << FW; m_off = 0; m_pincr = 0; m_poff = 0;
        m_pend = 0; m_run = 0; m_wrap = 0; acc_seen = 0;
    endtask

    task automatic m_apply_pend();
        if (m_pend) begin
            m_incr = m_pincr; m_off = m_poff; m_pend = 0;
        end
    endtask

    task automatic m_step();
        int unsigned sum;
        bit acc;
        acc = cfg_valid && !m_pend;
        acc_seen = acc;
        if (phase_clr) begin
            m_apply_pend();
            if (acc) begin m_incr = cfg_incr; m_off = cfg_offset; end
            m_phase = 0; m_wrap = 0; m_run = en;
        end else if (!m_run) begin
            if (acc) begin m_incr = cfg_incr; m_off = cfg_offset; end
            m_wrap = 0; m_run = en;
        end else if (!en) begin
            m_apply_pend();
            if (acc) begin m_incr = cfg_incr; m_off = cfg_offset; end
            m_wrap = 0; m_run = 0;
        end else begin
            sum     = m_phase + m_incr;
            m_wrap  = (sum >= MOD);
            m_phase = sum % MOD;
            if (m_wrap) m_apply_pend();
            if (acc) begin m_pincr = cfg_incr; m_poff = cfg_offset; m_pend = 1; end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else        m_step();
        q.push_back(snap());
    end

    // Asynchronous reset replaces whatever the current cycle was expected to show.
    always @(negedge rst_n) begin
        m_reset();
        if (q.size() > 0) begin
            q.delete();
            q.push_back(snap());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (addr1 !== e.addr || addr2 !== e.addr || offset !== e.off ||
                wrap !== e.wrap || cfg_ready !== e.rdy) begin
                errors++;
                $display("FAIL outputs t=%0t got addr1=%h addr2=%h offset=%h wrap=%b rdy=%b exp addr=%h offset=%h wrap=%b rdy=%b",
                         $time, addr1, addr2, offset, wrap, cfg_ready, e.addr, e.off, e.wrap, e.rdy);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fail_direct(input string name, input int got, input int exp);
        errors++;
        $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic offer(input int unsigned inc, input int unsigned off);
        bit done = 0;
        cfg_incr = P'(inc); cfg_offset = AW'(off); cfg_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            cyc();
            done = acc_seen;
        end
        cfg_valid = 1'b0;
        checks++;
        if (!done) fail_direct("cfg_accept_timeout", 0, 1);
    endtask

    task automatic wait_phase(input int unsigned ph);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (m_phase == ph) done = 1;
            else cyc();
        end
        checks++;
        if (!done) fail_direct("phase_wait_timeout", int'(m_phase), int'(ph));
    endtask

    initial begin
        rst_n = 1'b0;
        m_reset();
        repeat (3) cyc();
        rst_n = 1'b1;

        // Default increment sweep: every address, wrap once per 256 cycles.
        en = 1'b1;
        repeat (520) cyc();

        // Config loaded directly while idle, then half-speed stepping.
        en = 1'b0;
        cyc();
        offer(32'h0080, 64);
        repeat (2) cyc();
        en = 1'b1;
        repeat (40) cyc();

        // Offer landing on the carrying edge 0xFF00 -> 0x0000 waits a full period.
        phase_clr = 1'b1; cfg_valid = 1'b1; cfg_incr = 16'h0100; cfg_offset = 0;
        cyc();
        phase_clr = 1'b0; cfg_valid = 1'b0;
        wait_phase(32'hFF00);
        offer(32'h0200, 10);
        repeat (520) cyc();

        // Pending config applied when en drops mid-period.
        wait_phase(40 << FW);
        offer(32'h0300, 20);
        wait_phase(50 << FW);
        en = 1'b0;
        repeat (3) cyc();
        en = 1'b1;
        repeat (10) cyc();

        // Asynchronous reset while a config is pending.
        offer(32'h0080, 5);
        repeat (3) cyc();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (addr1 !== 0 || addr2 !== 0 || offset !== 0 || wrap !== 0 || cfg_ready !== 1)
            fail_direct("async_reset", {addr1, offset, 7'b0, wrap, 7'b0, cfg_ready}, 32'h0001);
        cyc();
        rst_n = 1'b1;
        repeat (300) cyc();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom_range(99) < 92);
            phase_clr = ($urandom_range(99) < 2);
            if (!(cfg_valid && !acc_seen)) begin
                cfg_valid = ($urandom_range(99) < 10);
                case ($urandom_range(5))
                    0: cfg_incr = 16'h0000;
                    1: cfg_incr = 16'h0080;
                    2: cfg_incr = 16'h0100;
                    3: cfg_incr = 16'h0200;
                    4: cfg_incr = 16'h1234;
                    default: cfg_incr = P'($urandom);
                endcase
                cfg_offset = AW'($urandom);
            end
            cyc();
        end
        cfg_valid = 1'b0; en = 1'b0; phase_clr = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
